car_odometer_ctrl: RTL and testbench

//  Sequences the mileage datapath from the car's move_forward/move_backward drive levels.

---
 rtl/car_odometer_ctrl.sv | 156 +++++++++++++++
 tb/tb_car_odometer_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/car_odometer_ctrl.sv
// Odometer sequencer: turns forward/backward drive levels into unit-distance ticks,
// enforces a dead-time gap on reversal and accumulates a wrapping mileage count.
module car_odometer_ctrl #(
  parameter int CLK_PER_UNIT = 100_000_000,
  parameter int REV_GAP      = 1000,
  parameter int MILE_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              move_forward,
  input  logic              move_backward,
  input  logic              clear_req,
  output logic              clear_ack,
  output logic              unit_tick,
  output logic [MILE_W-1:0] mile,
  output logic              rollover,
  output logic [1:0]        dir
);

  localparam int PW = $clog2(CLK_PER_UNIT);
  localparam int GW = $clog2(REV_GAP + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_UNIT - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(REV_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_BWD, S_GAP, S_CLEAR} state_t;
  typedef enum logic [1:0] {LD_NONE, LD_FWD, LD_BWD} ldir_t;

  state_t            r_state, w_state_nxt;
  ldir_t             r_ldir, w_ldir_nxt, w_gap_dir;
  logic [PW-1:0]     r_pre, w_pre_nxt;
  logic [GW-1:0]     r_gap, w_gap_nxt;
  logic [MILE_W-1:0] r_mile, w_mile_nxt;
  logic              r_roll, w_roll_nxt;
  logic              r_tick, w_tick_nxt;
  logic              r_ack, w_ack_nxt;
  logic [1:0]        r_dir, w_dir_nxt;
  logic              w_fwd_v, w_bwd_v, w_count, w_enter_gap;

  // Both levels high is ambiguous drive and counts as no motion.
  assign w_fwd_v = move_forward & ~move_backward;
  assign w_bwd_v = move_backward & ~move_forward;

  always_comb begin
    w_state_nxt = r_state;
    w_ldir_nxt  = r_ldir;
    w_pre_nxt   = r_pre;
    w_gap_nxt   = r_gap;
    w_mile_nxt  = r_mile;
    w_roll_nxt  = r_roll;
    w_tick_nxt  = 1'b0;
    w_ack_nxt   = 1'b0;
    w_count     = 1'b0;
    w_enter_gap = 1'b0;
    w_gap_dir   = LD_NONE;
    if (clear_req) begin
      w_state_nxt = S_CLEAR;
      w_ldir_nxt  = LD_NONE;
      w_pre_nxt   = '0;
      w_gap_nxt   = '0;
      w_mile_nxt  = '0;
      w_roll_nxt  = 1'b0;
      w_ack_nxt   = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fwd_v) begin
            if (r_ldir != LD_BWD) w_state_nxt = S_FWD;
            else begin w_enter_gap = 1'b1; w_gap_dir = LD_FWD; end
          end else if (w_bwd_v) begin
            if (r_ldir != LD_FWD) w_state_nxt = S_BWD;
            else begin w_enter_gap = 1'b1; w_gap_dir = LD_BWD; end
          end
        end
        S_FWD: begin
          w_ldir_nxt = LD_FWD;
          if (w_fwd_v)      w_count = 1'b1;
          else if (w_bwd_v) begin w_enter_gap = 1'b1; w_gap_dir = LD_BWD; end
          else              w_state_nxt = S_IDLE;
        end
        S_BWD: begin
          w_ldir_nxt = LD_BWD;
          if (w_bwd_v)      w_count = 1'b1;
          else if (w_fwd_v) begin w_enter_gap = 1'b1; w_gap_dir = LD_FWD; end
          else              w_state_nxt = S_IDLE;
        end
        S_GAP: begin
          if (r_gap == GAP_MAX) begin
            if (w_fwd_v && r_ldir == LD_FWD)      w_state_nxt = S_FWD;
            else if (w_bwd_v && r_ldir == LD_BWD) w_state_nxt = S_BWD;
            else                                  w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = r_gap + GW'(1);
          end
        end
        S_CLEAR: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Reversal always restarts the unit from zero in the new direction.
    if (w_enter_gap) begin
      w_state_nxt = S_GAP;
      w_ldir_nxt  = w_gap_dir;
      w_pre_nxt   = '0;
      w_gap_nxt   = '0;
    end

    if (w_count) begin
      if (r_pre == PRE_MAX) begin
        w_pre_nxt  = '0;
        w_mile_nxt = r_mile + MILE_W'(1);
        w_tick_nxt = 1'b1;
        if (&r_mile) w_roll_nxt = 1'b1;
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end

    unique case (w_state_nxt)
      S_FWD:   w_dir_nxt = 2'b01;
      S_BWD:   w_dir_nxt = 2'b10;
      default: w_dir_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ldir  <= LD_NONE;
      r_pre   <= '0;
      r_gap   <= '0;
      r_mile  <= '0;
      r_roll  <= 1'b0;
      r_tick  <= 1'b0;
      r_ack   <= 1'b0;
      r_dir   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_ldir  <= w_ldir_nxt;
      r_pre   <= w_pre_nxt;
      r_gap   <= w_gap_nxt;
      r_mile  <= w_mile_nxt;
      r_roll  <= w_roll_nxt;
      r_tick  <= w_tick_nxt;
      r_ack   <= w_ack_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign clear_ack = r_ack;
  assign unit_tick = r_tick;
  assign mile      = r_mile;
  assign rollover  = r_roll;
  assign dir       = r_dir;

endmodule

// File: tb/tb_car_odometer_ctrl.sv
// Bench for car_odometer_ctrl: directed scenarios plus random drive, two mileage widths
// sharing one stimulus, all checked against a unit-count reference model.
module tb_car_odometer_ctrl;
  localparam int CPU = 4;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst_n, fwd, bwd, clr;
  logic        ack16, tick16, roll16, ack4, tick4, roll4;
  logic [15:0] mile16;
  logic [3:0]  mile4;
  logic [1:0]  dir16, dir4;

  int n_chk = 0, n_err = 0, n_ticks = 0;

  always #5 clk = ~clk;

  car_odometer_ctrl #(.CLK_PER_UNIT(CPU), .REV_GAP(GAP), .MILE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .move_forward(fwd), .move_backward(bwd), .clear_req(clr),
    .clear_ack(ack16), .unit_tick(tick16), .mile(mile16), .rollover(roll16), .dir(dir16));

  car_odometer_ctrl #(.CLK_PER_UNIT(CPU), .REV_GAP(GAP), .MILE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .move_forward(fwd), .move_backward(bwd), .clear_req(clr),
    .clear_ack(ack4), .unit_tick(tick4), .mile(mile4), .rollover(roll4), .dir(dir4));

  // Reference: mode 0 idle, 1 forward, 2 backward, 3 dead-time, 4 clear.
  // Distance is kept as a total unit count since clear; mile and rollover derive from it.
  int     m_mode, m_last, m_phase, m_gap_left;
  longint m_units;
  bit     m_tick;

  function automatic void model_reset();
    m_mode = 0; m_last = 0; m_phase = 0; m_gap_left = 0; m_units = 0; m_tick = 0;
  endfunction

  function automatic void start_gap(int want);
    m_mode = 3; m_gap_left = GAP; m_phase = 0; m_last = want;
  endfunction

  function automatic void model_step(bit f, bit b, bit c);
    int want;
    want = (f && !b) ? 1 : ((b && !f) ? 2 : 0);
    m_tick = 0;
    if (c) begin
      m_mode = 4; m_units = 0; m_phase = 0; m_last = 0;
    end else begin
      case (m_mode)
        0: if (want != 0) begin
             if (m_last == 0 || m_last == want) m_mode = want;
             else start_gap(want);
           end
        1, 2: begin
          m_last = m_mode;
          if (want == m_mode) begin
            m_phase++;
            if (m_phase == CPU) begin m_phase = 0; m_units++; m_tick = 1; end
          end else if (want == 0) m_mode = 0;
          else start_gap(want);
        end
        3: begin
          m_gap_left--;
          if (m_gap_left == 0) m_mode = (want != 0 && want == m_last) ? m_last : 0;
        end
        default: m_mode = 0;
      endcase
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(string p);
    logic [31:0] ed;
    ed = (m_mode == 1) ? 1 : ((m_mode == 2) ? 2 : 0);
    chk({p, "_dir"},    {30'd0, dir16}, ed);
    chk({p, "_tick"},   {31'd0, tick16}, {31'd0, m_tick});
    chk({p, "_ack"},    {31'd0, ack16}, (m_mode == 4) ? 1 : 0);
    chk({p, "_mile"},   {16'd0, mile16}, 32'(m_units % 65536));
    chk({p, "_roll"},   {31'd0, roll16}, (m_units >= 65536) ? 1 : 0);
    chk({p, "_dir4"},   {30'd0, dir4}, ed);
    chk({p, "_tick4"},  {31'd0, tick4}, {31'd0, m_tick});
    chk({p, "_mile4"},  {28'd0, mile4}, 32'(m_units % 16));
    chk({p, "_roll4"},  {31'd0, roll4}, (m_units >= 16) ? 1 : 0);
  endtask

  // Inputs are driven just after an edge, the model advances on the edge, outputs sampled 1ns later.
  task automatic step(bit f, bit b, bit c, string p);
    fwd = f; bwd = b; clr = c;
    @(posedge clk);
    model_step(f, b, c);
    #1;
    if (tick16) n_ticks++;
    check_all(p);
  endtask

  task automatic do_reset(string p);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(p);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; fwd = 1'b0; bwd = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: steady forward, three units
    n_ticks = 0;
    step(1, 0, 0, "t1_go");
    chk("t1_dir_first", {30'd0, dir16}, 1);
    repeat (12) step(1, 0, 0, "t1");
    chk("t1_ticks", n_ticks, 3);
    chk("t1_mile", {16'd0, mile16}, 3);

    // 2: partial unit survives an idle pause
    do_reset("t2_rst");
    repeat (3) step(1, 0, 0, "t2a");
    repeat (5) step(0, 0, 0, "t2_idle");
    step(1, 0, 0, "t2_resume");
    step(1, 0, 0, "t2_c1");
    chk("t2_no_tick_c1", {31'd0, tick16}, 0);
    step(1, 0, 0, "t2_c2");
    chk("t2_tick_c2", {31'd0, tick16}, 1);
    chk("t2_mile", {16'd0, mile16}, 1);

    // 3: reversal dead-time and prescaler restart
    do_reset("t3_rst");
    repeat (4) step(1, 0, 0, "t3_fwd");
    repeat (3) begin
      step(0, 1, 0, "t3_gap");
      chk("t3_gap_dir", {30'd0, dir16}, 0);
    end
    step(0, 1, 0, "t3_gap_end");
    chk("t3_bwd_dir", {30'd0, dir16}, 2);
    repeat (4) step(0, 1, 0, "t3_bwd");
    chk("t3_bwd_tick", {31'd0, tick16}, 1);

    // 4: narrow counter wrap and sticky rollover
    do_reset("t4_rst");
    repeat (65) step(1, 0, 0, "t4");
    chk("t4_mile4", {28'd0, mile4}, 0);
    chk("t4_roll4", {31'd0, roll4}, 1);
    chk("t4_mile16", {16'd0, mile16}, 16);
    step(1, 0, 1, "t4_clr");
    step(0, 0, 0, "t4_rel");
    chk("t4_roll4_clr", {31'd0, roll4}, 0);

    // 5: clear collides with the tick edge
    do_reset("t5_rst");
    repeat (4) step(1, 0, 0, "t5_fwd");
    step(1, 0, 1, "t5_clr");
    chk("t5_no_tick", {31'd0, tick16}, 0);
    chk("t5_mile0", {16'd0, mile16}, 0);
    chk("t5_ack", {31'd0, ack16}, 1);
    repeat (2) step(1, 0, 1, "t5_hold");
    step(0, 0, 0, "t5_rel");
    chk("t5_ack_rel", {31'd0, ack16}, 0);
    chk("t5_dir_rel", {30'd0, dir16}, 0);

    // 6: both levels high, then async reset mid-motion
    do_reset("t6_rst");
    repeat (3) step(1, 0, 0, "t6_fwd");
    step(1, 1, 0, "t6_both");
    chk("t6_both_dir", {30'd0, dir16}, 0);
    repeat (3) step(1, 0, 0, "t6_resume");
    do_reset("t6_async");

    // Random drive held for short bursts, with occasional clears and resets
    for (int seg = 0; seg < 400; seg++) begin
      int r, len;
      bit f, b, c;
      r = $urandom_range(0, 19);
      len = $urandom_range(1, 12);
      f = 0; b = 0; c = 0;
      if (r < 8) f = 1;
      else if (r < 14) b = 1;
      else if (r < 16) begin f = 1; b = 1; end
      else if (r == 17) begin c = 1; len = $urandom_range(1, 3); end
      if (r == 19 && ($urandom_range(0, 1) == 1)) do_reset("rnd_rst");
      else repeat (len) step(f, b, c, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
